// File: rtl/tpu_pkg.sv
// Shared types for the matmul output path: element type and drain sequencer states.
package tpu_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic signed [DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO; a push while full is taken only when a pop happens in the same cycle.
module drain_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so the write port never shows stale data.
  assign head    = empty ? '0 : mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/output_drain_controller.sv
// Drains one result tile from the deskew stage into output memory through a small
// FIFO, writing vectors to consecutive addresses over a ready/valid port.
module output_drain_controller
  import tpu_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              busy,
  output logic              done,
  input  elem_t [N-1:0]     in_data,
  input  logic  [N-1:0]     in_valid,
  output logic [ADDR_W-1:0] out_addr,
  output elem_t [N-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_overflow,
  output logic              err_misalign
);

  localparam int unsigned WIDTH = N * DATA_W;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, wr_idx_q;
  logic [CNT_W-1:0]  count_q, rcv_cnt_q;
  logic              ovf_q, mis_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WIDTH-1:0]  fifo_head;
  logic [AW:0]       fifo_level;
  logic              arrival, partial, start_ok, in_drain, ovf_set;

  drain_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .level     (fifo_level)
  );

  assign arrival   = &in_valid;
  assign partial   = (|in_valid) & ~arrival;
  assign in_drain  = (state_q == DRAIN);
  assign start_ok  = (state_q == IDLE) & start;
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign fifo_push = in_drain & arrival & (~fifo_full | fifo_pop);
  assign ovf_set   = in_drain & arrival & fifo_full & ~fifo_pop;

  assign out_valid    = ~fifo_empty;
  assign out_data     = fifo_head;
  assign out_addr     = base_q + wr_idx_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err_overflow = ovf_q;
  assign err_misalign = mis_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (cfg_count == '0) ? DONE : DRAIN;
      DRAIN: if (arrival && (rcv_cnt_q + CNT_W'(1) == count_q)) state_d = FLUSH;
      // Leave as soon as the final pop happens rather than a cycle later.
      FLUSH: if (fifo_empty || (fifo_pop && fifo_level == (AW+1)'(1))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      rcv_cnt_q <= '0;
      wr_idx_q  <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q    <= cfg_base_addr;
        count_q   <= cfg_count;
        rcv_cnt_q <= '0;
        wr_idx_q  <= '0;
        ovf_q     <= 1'b0;
        mis_q     <= 1'b0;
      end else begin
        if (in_drain && arrival) rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
        if (fifo_pop)            wr_idx_q  <= wr_idx_q + ADDR_W'(1);
        if (ovf_set)             ovf_q     <= 1'b1;
        if (in_drain && partial) mis_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_drain_controller.sv
// Scoreboard bench: a queue-based reference model predicts every write; a negedge monitor checks.
module tb_output_drain_controller;
  import tpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_FLUSH = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_base_addr = '0;
  logic [15:0] cfg_count = '0;
  logic        busy, done;
  elem_t [1:0] in_data = '0;
  logic  [1:0] in_valid = '0;
  logic [15:0] out_addr;
  elem_t [1:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_overflow, err_misalign;

  output_drain_controller #(
    .N      (2),
    .DEPTH  (DEPTH),
    .ADDR_W (16),
    .CNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_count     (cfg_count),
    .busy          (busy),
    .done          (done),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_overflow  (err_overflow),
    .err_misalign  (err_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  exp_t        m_q[$];
  int          m_phase = P_IDLE;
  logic [15:0] m_base = '0;
  int          m_count = 0, m_rcv = 0, m_acc = 0;
  bit          m_ovf = 0, m_mis = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Applies one clock edge worth of spec rules to the model, using the inputs being driven.
  function automatic void model_step();
    bit pop = (m_q.size() > 0) && out_ready;
    int pre = m_q.size();
    int ph  = m_phase;
    if (pop) void'(m_q.pop_front());
    case (ph)
      P_IDLE: if (start) begin
        m_base  = cfg_base_addr;
        m_count = int'(cfg_count);
        m_rcv = 0; m_acc = 0; m_ovf = 0; m_mis = 0;
        m_phase = (m_count == 0) ? P_DONE : P_DRAIN;
      end
      P_DRAIN: begin
        if (in_valid == 2'b11) begin
          m_rcv++;
          if (pre < DEPTH || pop) begin
            exp_t e;
            e.addr = m_base + 16'(m_acc);
            e.data = in_data;
            m_q.push_back(e);
            m_acc++;
          end else m_ovf = 1;
          if (m_rcv == m_count) m_phase = P_FLUSH;
        end else if (in_valid != 2'b00) m_mis = 1;
      end
      P_FLUSH: if (m_q.size() == 0) m_phase = P_DONE;
      default: m_phase = P_IDLE;
    endcase
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_phase = P_IDLE; m_ovf = 0; m_mis = 0;
  endfunction

  // Monitor: compare DUT against the model away from the active edge.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      chk("busy", busy, m_phase != P_IDLE);
      chk("done", done, m_phase == P_DONE);
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_misalign", err_misalign, m_mis);
      if (out_valid && m_q.size() > 0) begin
        chk("out_addr", out_addr, m_q[0].addr);
        chk("out_data", out_data, m_q[0].data);
      end
      if (prev_stall && out_valid) begin
        chk("stall_addr_stable", out_addr, prev_addr);
        chk("stall_data_stable", out_data, prev_data);
      end
      prev_stall = out_valid & ~out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input logic [15:0] base, input logic [15:0] cnt);
    start = 1'b1; cfg_base_addr = base; cfg_count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vec();
    in_valid = 2'b11;
    in_data  = {16'($urandom), 16'($urandom)};
    tick();
    in_valid = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_phase != P_IDLE && n < budget) begin
      tick();
      n++;
    end
    if (m_phase != P_IDLE) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle: timeout after %0d cycles, phase %0d required %0d", n, m_phase,
               P_IDLE);
      model_reset();
    end
  endtask

  // Random traffic while a command runs; partial and idle lane patterns mixed in.
  task automatic run_random(input int budget);
    int n = 0;
    while (m_phase != P_IDLE && n < budget) begin
      int r = $urandom_range(0, 99);
      in_valid  = (r < 60) ? 2'b11 : (r < 68) ? 2'($urandom_range(1, 2)) : 2'b00;
      in_data   = {16'($urandom), 16'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    in_valid = 2'b00;
    out_ready = 1'b1;
    wait_idle(50);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", {err_overflow, err_misalign}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: three back-to-back vectors, always ready
    out_ready = 1'b1;
    issue(16'h0010, 16'd3);
    repeat (3) send_vec();
    wait_idle(20);

    // 2: overflow under stalled output
    out_ready = 1'b0;
    issue(16'h0100, 16'd6);
    repeat (6) send_vec();
    repeat (4) tick();
    chk("t2_overflow", err_overflow, 1);
    out_ready = 1'b1;
    wait_idle(20);

    // 3: partial lanes are flagged and not counted
    issue(16'h0200, 16'd2);
    in_valid = 2'b01; tick(); in_valid = 2'b00;
    chk("t3_misalign", err_misalign, 1);
    repeat (2) send_vec();
    wait_idle(20);

    // 4: zero-count command; a start while busy is ignored
    issue(16'h0300, 16'd0);
    chk("t4_busy", busy, 1);
    issue(16'h0400, 16'd5);
    chk("t4_idle_after", busy, 0);
    repeat (2) tick();

    // 5: reset during flush with two entries pending
    out_ready = 1'b0;
    issue(16'h0500, 16'd2);
    repeat (2) send_vec();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(16'h0600, 16'd2);
    repeat (2) send_vec();
    wait_idle(20);

    // 6: address wrap with random backpressure
    issue(16'hFFFF, 16'd2);
    run_random(200);

    // Random commands
    for (int c = 0; c < 8; c++) begin
      issue(16'($urandom), 16'($urandom_range(1, 9)));
      run_random(300);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
